// File: rtl/vector_result_streamer_if.sv
// Element-serial valid/ready stream carrying one result element per beat.
// The master drives data, valid and last; the slave returns ready.
interface vector_result_streamer_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/vector_result_streamer.sv
// Snapshots an ALU result vector and streams it out one element per beat,
// index 0 first, flagging the final beat and pulsing done on completion.
module vector_result_streamer #(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] S [N-1:0],
  input  logic [7:0]      S_len,
  input  logic            load,
  vector_result_streamer_if.master strm,
  output logic            busy,
  output logic            done,
  output logic            len_err,
  output logic            overrun
);

  localparam logic [7:0] NMAX = 8'(N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [BITS-1:0] shadow [N-1:0];
  logic [7:0]      cnt;
  logic [7:0]      len;
  logic            last_beat;
  logic            take;
  logic            accept;
  logic [IW-1:0]   idx;

  assign last_beat = (cnt == len - 8'd1);
  assign take      = (state == ST_SEND) && strm.out_ready;
  assign accept    = (state == ST_IDLE) && load;
  assign idx       = cnt[IW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (load) begin
          nxt = (S_len == 8'd0) ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (take && last_beat) begin
          nxt = ST_DONE;
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Shadow copy decouples the stream from later changes on S.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '{default: '0};
      cnt     <= 8'd0;
      len     <= 8'd0;
      len_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        shadow  <= S;
        len     <= (S_len > NMAX) ? NMAX : S_len;
        cnt     <= 8'd0;
        len_err <= (S_len > NMAX);
        overrun <= 1'b0;
      end else if (load) begin
        overrun <= 1'b1;
      end
      if (take && !last_beat) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    strm.out_data  = '0;
    strm.out_valid = 1'b0;
    strm.out_last  = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (1'b1)
      (state == ST_SEND): begin
        strm.out_data  = shadow[idx];
        strm.out_valid = 1'b1;
        strm.out_last  = last_beat;
        busy           = 1'b1;
      end
      (state == ST_DONE): begin
        strm.out_data  = shadow[idx];
        busy           = 1'b1;
        done           = 1'b1;
      end
      default: begin
        strm.out_data  = '0;
      end
    endcase
  end

endmodule
